// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch/decode front end.
package mips_pkg;

    // Bubble word: sll $0,$0,0
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // FETCH: request outstanding or issuing. HELD: a word was accepted under stall and is parked.
    typedef enum logic {
        FETCH = 1'b0,
        HELD  = 1'b1
    } fetch_state_t;

    // IF/ID pipeline register contents
    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selection for the fetch stage. A live redirect from decode wins over
// a redirect parked while memory was busy, which in turn wins over PC+4.
module pc_next_mux (
    input  logic [31:0] pc,
    input  logic        branch_taken,
    input  logic [31:0] pc_branch,
    input  logic        jump,
    input  logic [31:0] pc_jump,
    input  logic        redirect_pend,
    input  logic [31:0] pend_target,
    output logic        redirect,
    output logic [31:0] target,
    output logic [31:0] pc4,
    output logic [31:0] pc_next
);

    assign redirect = jump | branch_taken;
    assign target   = jump ? pc_jump : pc_branch;
    assign pc4      = pc + 32'd4;   // wraps naturally at 2^32

    // Priority: live redirect, then pending redirect, then sequential
    always_comb begin
        pc_next = pc4;
        if (redirect)           pc_next = target;
        else if (redirect_pend) pc_next = pend_target;
    end

endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction fetch stage with IF/ID register. Owns the PC, talks to
// instruction memory over req/ready, and applies stalls, redirects and flushes.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = mips_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall_in,
    input  logic        branch_taken_in,
    input  logic [31:0] pc_branch_in,
    input  logic        jump_in,
    input  logic [31:0] pc_jump_in,
    input  logic        if_flush_in,
    output logic [31:0] instruction_out,
    output logic [31:0] pc4_out,
    output logic        valid_out
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic         redirect_pend;
    logic [31:0]  pend_target;
    logic [31:0]  hold_word;
    if_id_t       if_id;

    logic         redirect;
    logic [31:0]  target;
    logic [31:0]  pc4;
    logic [31:0]  pc_next;

    pc_next_mux u_pc_next_mux (
        .pc            (pc),
        .branch_taken  (branch_taken_in),
        .pc_branch     (pc_branch_in),
        .jump          (jump_in),
        .pc_jump       (pc_jump_in),
        .redirect_pend (redirect_pend),
        .pend_target   (pend_target),
        .redirect      (redirect),
        .target        (target),
        .pc4           (pc4),
        .pc_next       (pc_next)
    );

    // A stall masks decode's redirect/flush; decode re-presents them later.
    logic redir_eff, flush_eff, squash, advance;
    logic [31:0] word;

    assign redir_eff = redirect & ~stall_in;
    assign flush_eff = if_flush_in & ~stall_in;
    // Any of these means the word being handed over must not reach decode.
    assign squash    = redir_eff | redirect_pend | flush_eff;
    // A word is ready to move into IF/ID: fresh from memory or parked in HELD.
    assign advance   = ~stall_in & ((state == HELD) | imem_ready);
    assign word      = (state == HELD) ? hold_word : imem_rdata;

    // Request is held low while reset is asserted and in HELD.
    assign imem_req        = (state == FETCH) & ~reset;
    assign imem_addr       = pc;
    assign instruction_out = if_id.instruction;
    assign pc4_out         = if_id.pc4;
    assign valid_out       = if_id.valid;

    // Fetch FSM, PC, pending redirect, parked word and IF/ID register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= FETCH;
            pc            <= RESET_PC;
            redirect_pend <= 1'b0;
            pend_target   <= '0;
            hold_word     <= '0;
            if_id         <= '{instruction: NOP_WORD, pc4: 32'h0, valid: 1'b0};
        end else if (advance) begin
            // Word delivered (or squashed); PC moves on.
            pc            <= pc_next;
            redirect_pend <= 1'b0;
            state         <= FETCH;
            if (squash) if_id <= '{instruction: NOP_WORD, pc4: pc4, valid: 1'b0};
            else        if_id <= '{instruction: word,     pc4: pc4, valid: 1'b1};
        end else if (state == FETCH && imem_ready) begin
            // Transfer completed under stall: park the word, keep PC.
            hold_word <= imem_rdata;
            state     <= HELD;
        end else if (state == FETCH && !stall_in) begin
            // Memory busy: address must stay put, so remember where to go
            // and mark the in-flight word for discard.
            if_id <= '{instruction: NOP_WORD, pc4: pc4, valid: 1'b0};
            if (redir_eff) begin
                redirect_pend <= 1'b1;
                pend_target   <= target;
            end else if (flush_eff && !redirect_pend) begin
                redirect_pend <= 1'b1;
                pend_target   <= pc4;
            end
        end
    end

endmodule
